// File: rtl/sd_emmc_cmd_master.sv
// SD/eMMC command-path master: issues commands to the CMD-line PHY,
// checks responses, retries on CRC/index errors, and waits out R1b busy.
module sd_emmc_cmd_master #(
    parameter int TIMEOUT_W       = 16,
    parameter int DEFAULT_TIMEOUT = 250,
    parameter int BUSY_W          = 24,
    parameter int MAX_RETRY       = 2,
    parameter int RETRY_GAP       = 8
) (
    input  logic                 sd_clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [5:0]           cmd_index_i,
    input  logic [31:0]          cmd_arg_i,
    input  logic [1:0]           rsp_type_i,
    input  logic                 check_crc_i,
    input  logic                 check_index_i,
    input  logic [TIMEOUT_W-1:0] timeout_i,
    input  logic [BUSY_W-1:0]    busy_timeout_i,
    input  logic                 abort_i,
    output logic [1:0]           setting_o,
    output logic [39:0]          cmd_o,
    output logic                 start_xfr_o,
    input  logic [119:0]         response_i,
    input  logic                 crc_ok_i,
    input  logic                 index_ok_i,
    input  logic                 finish_i,
    input  logic                 busy_i,
    output logic [7:0]           int_status_o,
    input  logic [7:0]           int_clr_i,
    output logic [31:0]          response_0_o,
    output logic [31:0]          response_1_o,
    output logic [31:0]          response_2_o,
    output logic [31:0]          response_3_o,
    output logic [2:0]           retry_cnt_o,
    output logic                 busy_o
);
    localparam int CW = (TIMEOUT_W > BUSY_W) ? TIMEOUT_W : BUSY_W;
    localparam int CC = 0, EI = 1, CTE = 2, CCRCE = 3;
    localparam int CIE = 4, DC = 5, BTE = 6, ABT = 7;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RSP, GAP, BUSY} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q;
    logic [1:0]           rsp_type_q;
    logic                 crc_chk_q, idx_chk_q;
    logic [TIMEOUT_W-1:0] limit_q;
    logic [BUSY_W-1:0]    blim_q;
    logic                 sync1_q, sync2_q;
    logic                 accept, crc_bad, idx_bad;
    logic                 pulse_d, retry_inc;
    logic [7:0]           int_set;

    assign cmd_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign accept      = cmd_valid_i & cmd_ready_o;
    assign crc_bad     = crc_chk_q & ~crc_ok_i;
    assign idx_bad     = idx_chk_q & ~index_ok_i;

    always_comb begin
        state_d   = state_q;
        int_set   = '0;
        pulse_d   = 1'b0;
        retry_inc = 1'b0;
        case (state_q)
            IDLE: if (accept) state_d = ISSUE;
            ISSUE: begin
                if (abort_i) begin
                    state_d = IDLE;
                    int_set[ABT] = 1'b1;
                    int_set[EI]  = 1'b1;
                end else begin
                    pulse_d = 1'b1;
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (abort_i) begin
                    state_d = IDLE;
                    int_set[ABT] = 1'b1;
                    int_set[EI]  = 1'b1;
                end else if (finish_i) begin
                    if (crc_bad | idx_bad) begin
                        if (retry_cnt_o < 3'(MAX_RETRY)) begin
                            retry_inc = 1'b1;
                            state_d   = GAP;
                        end else begin
                            int_set[CCRCE] = crc_bad;
                            int_set[CIE]   = idx_bad;
                            int_set[EI]    = 1'b1;
                            int_set[CC]    = 1'b1;
                            state_d = IDLE;
                        end
                    end else if (rsp_type_q == 2'b11) begin
                        state_d = BUSY;
                    end else begin
                        int_set[CC] = 1'b1;
                        state_d = IDLE;
                    end
                end else if (cnt_q == CW'(limit_q) - CW'(1)) begin
                    int_set[CTE] = 1'b1;
                    int_set[EI]  = 1'b1;
                    int_set[CC]  = 1'b1;
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (abort_i) begin
                    state_d = IDLE;
                    int_set[ABT] = 1'b1;
                    int_set[EI]  = 1'b1;
                end else if (cnt_q == CW'(RETRY_GAP - 1)) begin
                    state_d = ISSUE;
                end
            end
            BUSY: begin
                if (abort_i) begin
                    state_d = IDLE;
                    int_set[ABT] = 1'b1;
                    int_set[EI]  = 1'b1;
                end else if (!sync2_q) begin
                    int_set[DC] = 1'b1;
                    int_set[CC] = 1'b1;
                    state_d = IDLE;
                end else if (blim_q != '0 &&
                             cnt_q == CW'(blim_q) - CW'(1)) begin
                    int_set[BTE] = 1'b1;
                    int_set[EI]  = 1'b1;
                    int_set[CC]  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rsp_type_q   <= '0;
            crc_chk_q    <= 1'b0;
            idx_chk_q    <= 1'b0;
            limit_q      <= '0;
            blim_q       <= '0;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            setting_o    <= '0;
            cmd_o        <= '0;
            start_xfr_o  <= 1'b0;
            int_status_o <= '0;
            response_0_o <= '0;
            response_1_o <= '0;
            response_2_o <= '0;
            response_3_o <= '0;
            retry_cnt_o  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= (state_d == state_q) ? cnt_q + CW'(1) : '0;
            start_xfr_o <= pulse_d;
            // Chain is preset high outside BUSY so a fresh wait assumes busy.
            if (state_q == BUSY) begin
                sync1_q <= busy_i;
                sync2_q <= sync1_q;
            end else begin
                sync1_q <= 1'b1;
                sync2_q <= 1'b1;
            end
            if (accept) begin
                cmd_o        <= {2'b01, cmd_index_i, cmd_arg_i};
                setting_o    <= {rsp_type_i == 2'b10, rsp_type_i != 2'b00};
                rsp_type_q   <= rsp_type_i;
                crc_chk_q    <= check_crc_i;
                idx_chk_q    <= check_index_i;
                limit_q      <= (timeout_i == '0) ?
                                TIMEOUT_W'(DEFAULT_TIMEOUT) : timeout_i;
                blim_q       <= busy_timeout_i;
                int_status_o <= '0;
                retry_cnt_o  <= '0;
            end else begin
                int_status_o <= (int_status_o & ~int_clr_i) | int_set;
                if (retry_inc) retry_cnt_o <= retry_cnt_o + 3'd1;
            end
            if (state_q == WAIT_RSP && finish_i) begin
                if (rsp_type_q == 2'b10) begin
                    response_3_o <= {8'h00, response_i[119:96]};
                    response_2_o <= response_i[95:64];
                    response_1_o <= response_i[63:32];
                    response_0_o <= response_i[31:0];
                end else if (rsp_type_q != 2'b00) begin
                    response_0_o <= response_i[119:88];
                end
            end
        end
    end
endmodule
